// File: rtl/core_sequencer.sv
// Instruction sequencer FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP with timed memory handshakes.
// Latency: ALU op 4+ cycles (FETCH..WB); load 5+, store 4+, branch 3+ (plus memory wait cycles).
// Backpressure: req held until ack; no ack within TIMEOUT wait cycles traps the sequencer.
//
// Ports:
//   clock, reset_n          - rising-edge clock, asynchronous active-low reset
//   run                     - sequencing enable, only looked at on instruction boundaries
//   opcode[6:0]             - instr[6:0] from the instruction register, valid from DECODE onward
//   imem_req / imem_ack     - instruction fetch handshake (req is a Moore output)
//   dmem_req / dmem_we / dmem_ack - data memory handshake (req/we are Moore outputs)
//   ir_en, alu_en, rf_we, pc_en   - datapath strobes
//   trap / trap_clr         - sticky error flag and its clear request
//   state[2:0], instret[31:0] - current FSM state, retired instruction count
module core_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic [6:0]  opcode,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_en,
  output logic        alu_en,
  output logic        rf_we,
  output logic        pc_en,
  output logic        trap,
  input  logic        trap_clr,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] TMO = TIMEOUT[3:0];

  state_t     cur, nxt;
  logic [3:0] wcnt;
  logic [3:0] wcnt_inc;
  logic       wait_hit;
  logic       legal;
  logic       is_load;
  logic       is_store;
  logic       is_branch;
  state_t     boundary;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_ALU, OP_ALUI, OP_LOAD, OP_JALR, OP_STORE,
      OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
  end

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);

  // The cycle that would take the wait count to TIMEOUT is the last one
  // allowed; an ack arriving in that same cycle still completes normally.
  assign wcnt_inc = wcnt + 4'd1;
  assign wait_hit = (wcnt_inc == TMO);

  // End of an instruction: run decides whether to fetch again or park.
  assign boundary = run ? S_FETCH : S_IDLE;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur <= S_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt    = cur;
    ir_en  = 1'b0;
    alu_en = 1'b0;
    rf_we  = 1'b0;
    pc_en  = 1'b0;
    case (cur)
      S_IDLE: begin
        if (run) nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_en = 1'b1;
          nxt   = S_DECODE;
        end else if (wait_hit) begin
          nxt = S_TRAP;
        end
      end
      S_DECODE: begin
        nxt = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (is_load || is_store) begin
          nxt = S_MEM;
        end else if (is_branch) begin
          pc_en = 1'b1;
          nxt   = boundary;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (is_store) begin
            pc_en = 1'b1;
            nxt   = boundary;
          end else begin
            nxt = S_WB;
          end
        end else if (wait_hit) begin
          nxt = S_TRAP;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_en = 1'b1;
        nxt   = boundary;
      end
      S_TRAP: begin
        if (trap_clr) nxt = S_IDLE;
      end
      default: nxt = S_TRAP;
    endcase
  end

  // Wait counter restarts on every state change, so entering FETCH or MEM
  // (including FETCH straight from a boundary) always begins at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wcnt <= 4'd0;
    end else if (nxt != cur) begin
      wcnt <= 4'd0;
    end else if ((cur == S_FETCH && !imem_ack) || (cur == S_MEM && !dmem_ack)) begin
      wcnt <= wcnt_inc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instret <= 32'd0;
    end else if (pc_en) begin
      instret <= instret + 32'd1;
    end
  end

  // Moore outputs: decoded from the state register only, so reset drops
  // them immediately without waiting for a clock edge.
  assign imem_req = (cur == S_FETCH);
  assign dmem_req = (cur == S_MEM);
  assign dmem_we  = (cur == S_MEM) && is_store;
  assign trap     = (cur == S_TRAP);
  assign state    = cur;

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: the maximum number of wait cycles for an ack (4-bit range, 1..15).
REQ-002 SHALL have port clock, input, 1 bit: single clock, with all state updated on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port run, input, 1 bit: enables instruction sequencing, sampled only at instruction boundaries.
REQ-005 SHALL have port opcode, input, 7 bits: instr[6:0] from the instruction register, valid from DECODE onward.
REQ-006 SHALL have ports imem_req (output, 1 bit) and imem_ack (input, 1 bit): instruction fetch handshake.
REQ-007 SHALL have ports dmem_req (output, 1), dmem_we (output, 1) and dmem_ack (input, 1): data memory handshake.
REQ-008 SHALL have output ir_en, 1 bit: instruction register load strobe.
REQ-009 SHALL have outputs alu_en, rf_we and pc_en, 1 bit each: execute, register write and PC advance strobes.
REQ-010 SHALL have ports trap (output, 1 bit) and trap_clr (input, 1 bit): error flag and its clear request.
REQ-011 SHALL have outputs state, 3 bits (current FSM state) and instret, 32 bits (retired instruction count).

Function
REQ-012 SHALL encode states as IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; code 7 SHALL go to TRAP on the next edge.
REQ-013 SHALL, in IDLE, go to FETCH when run=1 and otherwise stay in IDLE.
REQ-014 SHALL, in FETCH, hold imem_req=1 until imem_ack=1.
- on ack: ir_en=1 for that cycle, then DECODE.
- an ack in the first FETCH cycle counts as a valid ack.
REQ-015 SHALL, in DECODE, take exactly 1 cycle.
- legal opcodes: 0110011, 0010011, 0000011, 1100111, 0100011, 1100011, 1101111, 0110111, 0010111.
- legal opcode -> EXEC; any other opcode -> TRAP.
REQ-016 SHALL, in EXEC, assert alu_en=1 for exactly 1 cycle, then branch on opcode:
- load (0000011) or store (0100011) -> MEM.
- branch (1100011) -> pc_en=1 in this cycle, then boundary.
- all other opcodes -> WB.
REQ-017 SHALL, in MEM, hold dmem_req=1 until dmem_ack=1, with dmem_we=1 throughout for stores and 0 for loads.
- load ack -> WB.
- store ack -> pc_en=1 in that cycle, then boundary.
REQ-018 SHALL, in WB, assert rf_we=1 and pc_en=1 for exactly 1 cycle, then boundary.
REQ-019 SHALL resolve a boundary to FETCH if run=1 in that cycle and to IDLE if run=0; deasserting run SHALL never abort an instruction in flight.
REQ-020 SHALL use a 4-bit wait counter that clears on entry to FETCH or MEM and increments each cycle the req is held without an ack.
- reaching TIMEOUT with no ack -> TRAP.
- an ack in the same cycle the counter reaches TIMEOUT wins (no trap).
REQ-021 SHALL, in TRAP, hold trap=1 with all strobes and reqs at 0; trap_clr=1 -> IDLE; trap_clr outside TRAP is ignored.
REQ-022 SHALL increment instret on every cycle with pc_en=1, wrapping from 0xFFFFFFFF to 0.
REQ-023 SHALL assert at most one of ir_en, alu_en and rf_we in any cycle.
REQ-024 SHALL drive imem_req and dmem_req as Moore outputs decoded from state only.

Reset
REQ-025 SHALL, while reset_n=0 (asynchronously), force state=IDLE, instret=0, wait counter=0, and every output strobe, req and trap to 0.
REQ-026 SHALL, on reset assertion mid-handshake, drop the req immediately, and SHALL ignore any late ack.
REQ-027 SHALL restart sequencing on the first rising edge after reset_n rises, only if run=1.

Verification
REQ-028 SHALL cover an ALU op: run=1, opcode 0110011, imem_ack on the 2nd FETCH cycle.
- required: states 1,1,2,3,5,1; ir_en, alu_en and rf_we each pulse once; instret=1.
REQ-029 SHALL cover a store: opcode 0100011, dmem_ack after 3 cycles.
- required: dmem_req=1 and dmem_we=1 for 3 cycles; pc_en pulses on the ack cycle; rf_we never asserts; instret increments by 1.
REQ-030 SHALL cover an illegal opcode: opcode 0000000.
- required: DECODE -> TRAP; trap=1 held; trap_clr=1 -> IDLE next cycle; instret unchanged.
REQ-031 SHALL cover a fetch timeout: TIMEOUT=4, imem_ack held at 0.
- required: TRAP entered after 4 wait cycles.
- repeat with ack on the 4th cycle -> DECODE, no trap.
REQ-032 SHALL cover run deasserted during MEM of a load.
- required: the load completes (WB, rf_we=1), then IDLE; no further imem_req.
REQ-033 SHALL cover an async reset asserted mid-MEM.
- required: dmem_req=0 and state=0 immediately, without waiting for a clock edge; instret=0.
